// File: rtl/keyboard_ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package keyboard_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Bit positions inside the sticky error vector.
  localparam int ERR_PARITY   = 0;
  localparam int ERR_FRAME    = 1;
  localparam int ERR_TIMEOUT  = 2;
  localparam int ERR_OVERFLOW = 3;
  localparam int ERR_W        = 4;

endpackage

// File: rtl/keyboard_ps2_rx_fifo.sv
// Receive byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module keyboard_ps2_rx_fifo #(
  parameter int P_DEPTH = 8
) (
  input  logic                       iCLOCK,
  input  logic                       inRESET,
  input  logic                       iRESET_SYNC,
  input  logic                       iPUSH,
  input  logic [7:0]                 iDATA,
  input  logic                       iPOP,
  output logic [7:0]                 oDATA,
  output logic                       oFULL,
  output logic                       oEMPTY,
  output logic [$clog2(P_DEPTH):0]   oCOUNT
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [P_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          pushAcc;
  logic          popAcc;

  assign oFULL   = (count == CW'(P_DEPTH));
  assign oEMPTY  = (count == '0);
  assign popAcc  = iPOP & ~oEMPTY;
  assign pushAcc = iPUSH & (~oFULL | popAcc);
  assign oDATA   = mem[rdPtr];
  assign oCOUNT  = count;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (iRESET_SYNC) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + 1'b1;
      if (popAcc)  rdPtr <= rdPtr + 1'b1;
      if (pushAcc && !popAcc)      count <= count + 1'b1;
      else if (popAcc && !pushAcc) count <= count - 1'b1;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (pushAcc) mem[wrPtr] <= iDATA;
  end

endmodule

// File: rtl/keyboard_ps2_rx_ctrl.sv
// PS/2 keyboard receiver: line synchronizer and glitch filter, frame decoder FSM,
// receive FIFO and sticky error flags. oFSM_STATE exposes the decoder state.
module keyboard_ps2_rx_ctrl
  import keyboard_ps2_pkg::*;
#(
  parameter int P_FIFO_DEPTH     = 8,
  parameter int P_FILTER_CYCLES  = 1250,
  parameter int P_TIMEOUT_CYCLES = 100000
) (
  input  logic                             iCLOCK,
  input  logic                             inRESET,
  input  logic                             iRESET_SYNC,
  input  logic                             iPS2_CLOCK,
  input  logic                             iPS2_DATA,
  output logic                             oDATA_VALID,
  output logic [7:0]                       oDATA,
  input  logic                             iDATA_READY,
  output logic [$clog2(P_FIFO_DEPTH):0]    oCOUNT,
  output logic                             oERR_PARITY,
  output logic                             oERR_FRAME,
  output logic                             oERR_TIMEOUT,
  output logic                             oERR_OVERFLOW,
  input  logic                             iERR_CLEAR,
  output logic [1:0]                       oFSM_STATE
);

  localparam int FW = $clog2(P_FILTER_CYCLES + 1);
  localparam int TW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(P_FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(P_TIMEOUT_CYCLES - 1);

  // Index 0 carries the PS/2 clock, index 1 the PS/2 data line.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          clkPrev;
  logic          fall;
  logic          sample;

  ps2_state_e    state, stateNext;
  logic [2:0]    bitCnt, bitCntNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          parBit, parNext;
  logic [TW-1:0] toCnt;
  logic          push;
  logic          pop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [7:0]    fifoHead;
  logic [ERR_W-1:0] errSet;
  logic [ERR_W-1:0] errFlags;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      clkPrev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else if (iRESET_SYNC) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      clkPrev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1   <= {iPS2_DATA, iPS2_CLOCK};
      sync2   <= sync1;
      clkPrev <= filt[0];
      // A differing value must persist for P_FILTER_CYCLES in a row to be adopted.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall   = clkPrev & ~filt[0];
  assign sample = filt[1];

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state    <= ST_IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      parBit   <= 1'b0;
      toCnt    <= '0;
    end else if (iRESET_SYNC) begin
      state    <= ST_IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      parBit   <= 1'b0;
      toCnt    <= '0;
    end else begin
      state    <= stateNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
      parBit   <= parNext;
      toCnt    <= (state == ST_IDLE || fall) ? '0 : toCnt + 1'b1;
    end
  end

  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    parNext    = parBit;
    push       = 1'b0;
    errSet     = '0;
    if (state != ST_IDLE && !fall && toCnt == TO_LAST) begin
      stateNext           = ST_IDLE;
      errSet[ERR_TIMEOUT] = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!sample) begin
            stateNext  = ST_DATA;
            bitCntNext = '0;
          end
        end
        ST_DATA: begin
          shiftNext  = {sample, shiftReg[7:1]};
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7) stateNext = ST_PARITY;
        end
        ST_PARITY: begin
          parNext   = sample;
          stateNext = ST_STOP;
        end
        ST_STOP: begin
          // A bad stop bit masks any parity result.
          if (!sample)                 errSet[ERR_FRAME]  = 1'b1;
          else if (^{shiftReg, parBit}) push              = 1'b1;
          else                         errSet[ERR_PARITY] = 1'b1;
          stateNext = ST_IDLE;
        end
        default: stateNext = ST_IDLE;
      endcase
    end
    errSet[ERR_OVERFLOW] = push & fifoFull & ~pop;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)        errFlags <= '0;
    else if (iRESET_SYNC) errFlags <= '0;
    else                 errFlags <= (iERR_CLEAR ? '0 : errFlags) | errSet;
  end

  keyboard_ps2_rx_fifo #(
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iPUSH       (push),
    .iDATA       (shiftReg),
    .iPOP        (pop),
    .oDATA       (fifoHead),
    .oFULL       (fifoFull),
    .oEMPTY      (fifoEmpty),
    .oCOUNT      (oCOUNT)
  );

  assign oDATA_VALID   = ~fifoEmpty;
  assign pop           = oDATA_VALID & iDATA_READY;
  assign oDATA         = oDATA_VALID ? fifoHead : 8'h00;
  assign oERR_PARITY   = errFlags[ERR_PARITY];
  assign oERR_FRAME    = errFlags[ERR_FRAME];
  assign oERR_TIMEOUT  = errFlags[ERR_TIMEOUT];
  assign oERR_OVERFLOW = errFlags[ERR_OVERFLOW];
  assign oFSM_STATE    = state;

endmodule

// File: tb/tb_keyboard_ps2_rx_ctrl.sv
// Bench for keyboard_ps2_rx_ctrl: directed PS/2 frames, scoreboard on popped bytes.
module tb_keyboard_ps2_rx_ctrl;
  import keyboard_ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst_sync;
  logic       ps2_clk;
  logic       ps2_data;
  logic       data_valid;
  logic [7:0] data;
  logic       data_ready;
  logic [2:0] count;
  logic       err_parity, err_frame, err_timeout, err_overflow;
  logic       err_clear;
  logic [1:0] fsm_state;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  keyboard_ps2_rx_ctrl #(
    .P_FIFO_DEPTH     (DEPTH),
    .P_FILTER_CYCLES  (2),
    .P_TIMEOUT_CYCLES (64)
  ) dut (
    .iCLOCK        (clk),
    .inRESET       (rst_n),
    .iRESET_SYNC   (rst_sync),
    .iPS2_CLOCK    (ps2_clk),
    .iPS2_DATA     (ps2_data),
    .oDATA_VALID   (data_valid),
    .oDATA         (data),
    .iDATA_READY   (data_ready),
    .oCOUNT        (count),
    .oERR_PARITY   (err_parity),
    .oERR_FRAME    (err_frame),
    .oERR_TIMEOUT  (err_timeout),
    .oERR_OVERFLOW (err_overflow),
    .iERR_CLEAR    (err_clear),
    .oFSM_STATE    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // driver tasks; each starts and ends #1 after a rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(HALF);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    cycles(10);
  endtask

  task automatic pop_one();
    data_ready = 1'b1;
    cycles(1);
    data_ready = 1'b0;
    cycles(1);
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    cycles(1);
    err_clear = 1'b0;
    cycles(1);
  endtask

  task automatic check_flags(input string name, input logic [3:0] exp);
    @(negedge clk);
    check(name, {err_overflow, err_timeout, err_frame, err_parity}, exp);
  endtask

  // scoreboard monitor: compares every accepted head byte
  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no byte", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", data, e);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    rst_sync   = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    data_ready = 1'b0;
    err_clear  = 1'b0;

    @(negedge clk);
    check("reset_valid", {31'd0, data_valid}, 0);
    check("reset_data", {24'd0, data}, 0);
    check("reset_count", {29'd0, count}, 0);
    check("reset_state", {30'd0, fsm_state}, ST_IDLE);
    check_flags("reset_flags", 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(4);

    // good frame 0x1C: 0,00111000,0,1
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    @(negedge clk);
    check("good_valid", {31'd0, data_valid}, 1);
    check("good_data", {24'd0, data}, 32'h1C);
    check("good_count", {29'd0, count}, 1);
    check_flags("good_flags", 4'b0000);
    cycles(1);
    pop_one();
    @(negedge clk);
    check("good_popped_count", {29'd0, count}, 0);
    check("empty_data_zero", {24'd0, data}, 0);
    cycles(1);

    // bad parity
    send_frame(8'h1C, 1'b1, 1'b1);
    @(negedge clk);
    check("par_count", {29'd0, count}, 0);
    check_flags("par_flags", 4'b0001);
    cycles(1);
    clear_errors();
    check_flags("par_cleared", 4'b0000);
    cycles(1);

    // bad stop bit; parity is correct so only the frame error may show
    send_frame(8'h55, odd_par(8'h55), 1'b0);
    @(negedge clk);
    check("frame_count", {29'd0, count}, 0);
    check_flags("frame_flags", 4'b0010);
    cycles(1);
    clear_errors();

    // overflow: five frames, consumer stalled
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i <= DEPTH) exp_q.push_back(b);
      send_frame(b, odd_par(b), 1'b1);
    end
    @(negedge clk);
    check("ovf_count", {29'd0, count}, 4);
    check("ovf_head", {24'd0, data}, 32'h01);
    check_flags("ovf_flags", 4'b1000);
    cycles(1);
    for (int i = 0; i < DEPTH; i++) pop_one();
    @(negedge clk);
    check("ovf_drained_count", {29'd0, count}, 0);
    check("ovf_drained_valid", {31'd0, data_valid}, 0);
    cycles(1);
    clear_errors();

    // timeout: clock stops after four data bits
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    check("to_midframe_state", {30'd0, fsm_state}, ST_DATA);
    cycles(100);
    @(negedge clk);
    check("to_state", {30'd0, fsm_state}, ST_IDLE);
    check_flags("to_flags", 4'b0100);
    cycles(1);
    clear_errors();
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, odd_par(8'hAA), 1'b1);
    @(negedge clk);
    check("to_next_count", {29'd0, count}, 1);
    check_flags("to_next_flags", 4'b0000);
    cycles(1);
    pop_one();

    // one-cycle glitch on the PS/2 clock with data low
    ps2_data = 1'b0;
    cycles(10);
    ps2_clk = 1'b0;
    cycles(1);
    ps2_clk = 1'b1;
    cycles(10);
    @(negedge clk);
    check("glitch_state", {30'd0, fsm_state}, ST_IDLE);
    check_flags("glitch_flags", 4'b0000);
    cycles(1);
    ps2_data = 1'b1;
    cycles(10);

    // reset in the middle of a frame with a byte queued and an error set
    send_frame(8'h12, odd_par(8'h12), 1'b1);
    send_frame(8'h12, ~odd_par(8'h12), 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    @(negedge clk);
    check("prereset_count", {29'd0, count}, 1);
    check("prereset_state", {30'd0, fsm_state}, ST_DATA);
    cycles(1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, data_valid}, 0);
    check("midrst_data", {24'd0, data}, 0);
    check("midrst_count", {29'd0, count}, 0);
    check("midrst_state", {30'd0, fsm_state}, ST_IDLE);
    check_flags("midrst_flags", 4'b0000);
    cycles(1);
    ps2_data = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    @(negedge clk);
    check("postrst_count", {29'd0, count}, 1);
    check_flags("postrst_flags", 4'b0000);
    cycles(1);
    pop_one();

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_ps2_rx_ctrl.md
KEYBOARD_PS2_RX_CTRL -- requirements
Module: keyboard_ps2_rx_ctrl

Interface
REQ-001 SHALL have parameter P_FIFO_DEPTH, default 8, receive FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter P_FILTER_CYCLES, default 1250, glitch-filter stable time in iCLOCK cycles (25 us at 50 MHz).
REQ-003 SHALL have parameter P_TIMEOUT_CYCLES, default 100000, maximum iCLOCK cycles between PS/2 clock falling edges within a frame (2 ms at 50 MHz).
REQ-004 SHALL have port iCLOCK, input, 1, system clock, rising edge.
REQ-005 SHALL have port inRESET, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port iRESET_SYNC, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports iPS2_CLOCK and iPS2_DATA, input, 1 each, raw asynchronous PS/2 lines.
REQ-008 SHALL have port oDATA_VALID, output, 1, FIFO head holds a valid byte.
REQ-009 SHALL have port oDATA, output, 8, FIFO head byte; 0x00 when oDATA_VALID=0.
REQ-010 SHALL have port iDATA_READY, input, 1, consumer accepts the head byte.
REQ-011 SHALL have port oCOUNT, output, $clog2(P_FIFO_DEPTH)+1, FIFO occupancy.
REQ-012 SHALL have ports oERR_PARITY, oERR_FRAME, oERR_TIMEOUT, oERR_OVERFLOW, output, 1 each, sticky error flags.
REQ-013 SHALL have port iERR_CLEAR, input, 1, clears all sticky error flags.

Function
REQ-014 SHALL pass both PS/2 lines through a 2-flop synchronizer, then a filter whose output takes a new value only after the synchronized input holds that value for P_FILTER_CYCLES consecutive cycles.
REQ-015 SHALL detect falling edges of the filtered clock (previous 1, current 1->0); each edge samples filtered data once.
REQ-016 SHALL implement FSM IDLE, DATA, PARITY, STOP.
REQ-017 SHALL, in IDLE: sample 0 -> DATA with bit counter 0; sample 1 -> stay in IDLE, no flag.
REQ-018 SHALL, in DATA: shift in LSB first; after the 8th sample -> PARITY.
REQ-019 SHALL, in PARITY: store the sample -> STOP.
REQ-020 SHALL, in STOP: sample 1 with odd parity over 9 bits -> push the byte; parity bad -> set oERR_PARITY, no push; sample 0 -> set oERR_FRAME, no push (frame error takes priority over parity). Always -> IDLE.
REQ-021 SHALL, outside IDLE, count cycles since the last falling edge; on reaching P_TIMEOUT_CYCLES -> IDLE, discard partial byte, set oERR_TIMEOUT.
REQ-022 SHALL show a pushed byte on oDATA_VALID/oDATA in the cycle after the stop-bit edge cycle when the FIFO was empty.
REQ-023 SHALL pop when oDATA_VALID & iDATA_READY; iDATA_READY while empty has no effect.
REQ-024 SHALL, on push into a full FIFO without a same-cycle pop, drop the byte and set oERR_OVERFLOW; push and pop together when full are both accepted, oCOUNT unchanged.
REQ-025 SHALL wrap FIFO pointers modulo P_FIFO_DEPTH; oCOUNT ranges 0..P_FIFO_DEPTH.
REQ-026 SHALL let a same-cycle error set win over iERR_CLEAR.

Reset
REQ-027 SHALL, on inRESET low (async) or iRESET_SYNC high (sync), drive FSM IDLE, counters 0, FIFO empty, filter outputs 1, oDATA_VALID=0, oDATA=0x00, oCOUNT=0, all error flags 0.
REQ-028 SHALL discard any frame in progress on reset; the next frame is decoded only from a fresh start bit.

Structure
REQ-029 SHALL place the FSM state enum and error-flag index constants in package keyboard_ps2_pkg.
REQ-030 SHALL implement the FIFO as sub-module keyboard_ps2_rx_fifo (parameter depth; push, pop, full, empty, count).

Verification (bench: P_FILTER_CYCLES=2, P_TIMEOUT_CYCLES=64, P_FIFO_DEPTH=4)
REQ-031 SHALL check: frame 0,00111000,0,1 (byte 0x1C) -> oDATA=0x1C, oDATA_VALID=1, oCOUNT=1, no errors.
REQ-032 SHALL check: 0x1C with parity 1 -> no push, oERR_PARITY=1; iERR_CLEAR pulse -> 0.
REQ-033 SHALL check: 0x55 with stop bit 0 -> no push, oERR_FRAME=1.
REQ-034 SHALL check: 5 frames 0x01..0x05 with iDATA_READY=0 -> oCOUNT=4, oERR_OVERFLOW=1; pops return 0x01..0x04.
REQ-035 SHALL check: clock stops after 4 data bits for 100 cycles -> oERR_TIMEOUT=1, FSM IDLE; next frame 0xAA decoded correctly.
REQ-036 SHALL check: 1-cycle PS/2 clock glitch -> no edge detected, FSM stays IDLE; inRESET low mid-frame -> all outputs at reset values.
